timer_unit: RTL
===============

Name: timer_unit

Overview:
- Timer peripheral that answers the MCU controller's timer control interface.
- The controller drives four level-held control bits (cs, wr, start, rd) from its TC register, plus a 16-bit load word.
- This block loads a reload value, counts down, raises a sticky interrupt on expiry and exposes the count for readback.
- It sits beside the controller and feeds timer_value and timer_INT back to it.

Parameters:
PRESCALE, 1, clock cycles per count decrement (>=1)
AUTO_RELOAD, 1, 1 = periodic (reload on expiry), 0 = one-shot (stop in DONE)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
timer_cs  input  1  chip select; gates all other control inputs
timer_wr  input  1  level; rising edge of cs&wr loads timer_datain
timer_start  input  1  level; cs&start high = run
timer_rd  input  1  level; cs&rd high = timer_value tracks count
timer_datain  input  16  reload value
timer_value  output  16  readback snapshot of count
timer_INT  output  1  sticky expiry interrupt, level
timer_busy  output  1  1 while state is RUN

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst.
- Reset values:
  - reload, count, timer_value = 0.
  - prescale count = 0.
  - timer_INT = 0, timer_busy = 0.
  - state = IDLE.
  - wr_q and run_q edge registers = 0.
- Effective controls: ld = cs & wr & ~wr_q (edge-detected); run = cs & start; rdv = cs & rd.
- Load (ld):
  - reload <= datain, count <= datain, prescale count <= 0, timer_INT <= 0.
  - Next state = RUN if run, else IDLE.
  - Load has priority over a same-cycle tick or expiry.
- FSM states: IDLE, RUN, DONE.
  - IDLE: count holds. Go to RUN when run=1 and reload != 0. If reload == 0, stay IDLE; the interrupt never fires.
  - RUN: prescale count increments each cycle; a tick occurs when it reaches PRESCALE-1, then it wraps to 0.
  - On a tick with count > 1: count <= count - 1.
  - On a tick with count <= 1 (expiry): timer_INT <= 1. If AUTO_RELOAD, count <= reload and stay in RUN. Otherwise count <= 0 and go to DONE.
  - run falling (run_q=1, run=0) while in RUN: go to IDLE, count holds (pause), timer_INT <= 0. Resuming continues from the held count.
  - DONE: count = 0. A load exits as above. run falling: count <= reload, go to IDLE, timer_INT <= 0.
- Timing and period:
  - Periodic expiry every reload*PRESCALE cycles.
  - The first expiry occurs reload*PRESCALE cycles after the first RUN cycle.
  - timer_INT rises in the cycle after the expiring tick edge.
- Readback: while rdv, timer_value <= count every cycle (one-cycle lag); otherwise timer_value holds.
- timer_INT stays high until a load edge or a run falling edge. A further expiry while it is high keeps it high.
- cs low: ld, run and rdv are all 0. The run falling rule then applies (deselect pauses the timer); wr_q and run_q keep sampling.
- Arithmetic: count and reload are unsigned 16-bit; no wrap below 0 is possible. Reload 1 expires on every tick.
- Reset mid-count: all state returns to reset values immediately.

Decomposition:
- Package timer_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - TC bit index constants CS=3, WR=2, START=1, RD=0;
  - reload width constant 16.
- One sub-module, timer_prescaler (PRESCALE parameter): inputs clk, rst, en, clr; output tick.

Test Plan:
- Reset, then load 5 (PRESCALE=1, AUTO_RELOAD=1), start -> timer_INT rises 5 cycles after RUN entry; stays high; count reloads to 5 and repeats every 5 cycles.
- Load 3, start, rd held -> timer_value sequence 3,2,1,3,... lagging count by one cycle; drop rd -> timer_value frozen.
- AUTO_RELOAD=0, load 4, start -> INT after 4 cycles, state DONE, count 0; drop start -> INT=0, count=4, IDLE.
- PRESCALE=4, load 2, start; drop cs after 3 cycles for 10 cycles, then restore -> count paused at 2, INT at 8 active cycles total.
- wr edge in the same cycle as expiry (load 7) -> INT stays 0, count=7; wr held high for 5 cycles loads only once; reload 0 + start -> no INT, timer_busy=0.
- Assert rst low mid-run with INT=1 -> all outputs 0 asynchronously; release -> IDLE until a new load.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer peripheral.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // Bit positions of the controller's TC register control bits.
    localparam int unsigned CS    = 3;
    localparam int unsigned WR    = 2;
    localparam int unsigned START = 1;
    localparam int unsigned RD    = 0;

    localparam int unsigned RELOAD_W = 16;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock down to one tick every PRESCALE enabled cycles.
// The phase is held while en is low so a paused timer resumes mid-period.
module timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] pcnt;

    assign tick = en && (pcnt == LAST);

    // Phase counter: cleared on load, advances only while running, wraps on tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + ONE;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Down-counting timer peripheral: load, run/pause, sticky expiry interrupt
// and a readback snapshot of the count.
//
// state | meaning
// IDLE  | stopped or paused; count holds
// RUN   | counting down on prescaler ticks
// DONE  | one-shot expired; count is 0 until load or run falls
module timer_unit
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned AUTO_RELOAD = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                timer_cs,
    input  logic                timer_wr,
    input  logic                timer_start,
    input  logic                timer_rd,
    input  logic [RELOAD_W-1:0] timer_datain,
    output logic [RELOAD_W-1:0] timer_value,
    output logic                timer_INT,
    output logic                timer_busy
);

    localparam logic [RELOAD_W-1:0] ONE = RELOAD_W'(1);

    timer_state_t        state;
    logic [RELOAD_W-1:0] reload;
    logic [RELOAD_W-1:0] count;
    logic                wr_q;
    logic                run_q;

    logic [3:0] tc;
    logic       wr_eff;
    logic       ld;
    logic       run;
    logic       rdv;
    logic       run_fall;
    logic       tick;
    logic       pre_en;

    assign tc       = {timer_cs, timer_wr, timer_start, timer_rd};
    assign wr_eff   = tc[CS] & tc[WR];
    assign ld       = wr_eff & ~wr_q;
    assign run      = tc[CS] & tc[START];
    assign rdv      = tc[CS] & tc[RD];
    assign run_fall = run_q & ~run;

    // The cycle in which run falls is not a counting cycle, so the phase is preserved.
    assign pre_en = (state == RUN) && run;

    timer_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (pre_en),
        .clr (ld),
        .tick(tick)
    );

    // Control FSM, count, interrupt, readback and edge registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            reload      <= '0;
            count       <= '0;
            timer_value <= '0;
            timer_INT   <= 1'b0;
            timer_busy  <= 1'b0;
            wr_q        <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            wr_q  <= wr_eff;
            run_q <= run;

            if (rdv) begin
                timer_value <= count;
            end

            if (ld) begin
                reload    <= timer_datain;
                count     <= timer_datain;
                timer_INT <= 1'b0;
                // A zero reload can never expire, so it is never allowed into RUN.
                if (run && (timer_datain != '0)) begin
                    state      <= RUN;
                    timer_busy <= 1'b1;
                end else begin
                    state      <= IDLE;
                    timer_busy <= 1'b0;
                end
            end else if (run_fall) begin
                timer_INT <= 1'b0;
                case (state)
                    RUN: begin
                        state      <= IDLE;
                        timer_busy <= 1'b0;
                    end
                    DONE: begin
                        count      <= reload;
                        state      <= IDLE;
                        timer_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (run && (reload != '0)) begin
                            state      <= RUN;
                            timer_busy <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (count > ONE) begin
                                count <= count - ONE;
                            end else begin
                                timer_INT <= 1'b1;
                                if (AUTO_RELOAD != 0) begin
                                    count <= reload;
                                end else begin
                                    count      <= '0;
                                    state      <= DONE;
                                    timer_busy <= 1'b0;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
